// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared widths and state encoding for the MEM-stage data-RAM sequencer
package mem_access_ctrl_pkg;

    localparam int DATA_BUS_WIDTH     = 32;
    localparam int ADDR_BUS_WIDTH     = 32;
    localparam int MEM_SEL_BUS_WIDTH  = 4;
    localparam int MEM_CTRL_STATE_BUS = 2;

    typedef enum logic [MEM_CTRL_STATE_BUS-1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_ctrl_state_e;

endpackage

// File: rtl/mem_access_ctrl_align_check.sv
// rtl/mem_access_ctrl_align_check.sv - byte-select / address legality check for one access
module mem_access_ctrl_align_check
    import mem_access_ctrl_pkg::*;
#(
    parameter int SEL_W = MEM_SEL_BUS_WIDTH
) (
    input  logic [SEL_W-1:0] sel_i,
    input  logic [1:0]       addr_lsb_i,
    output logic             aligned_o
);

    localparam logic [SEL_W-1:0] SEL_LO_HALF = SEL_W'(4'b0011);
    localparam logic [SEL_W-1:0] SEL_HI_HALF = SEL_W'(4'b1100);
    localparam logic [SEL_W-1:0] SEL_FULL    = '1;

    logic single_lane;
    logic half_word;
    logic full_word;

    // A lone byte lane can sit anywhere; halves need even addresses, full words need word addresses
    always_comb begin
        single_lane = (sel_i != '0) && ((sel_i & (sel_i - SEL_W'(1))) == '0);
        half_word   = (sel_i == SEL_LO_HALF) || (sel_i == SEL_HI_HALF);
        full_word   = (sel_i == SEL_FULL);
        aligned_o   = single_lane
                    | (half_word & ~addr_lsb_i[0])
                    | (full_word & (addr_lsb_i == 2'b00));
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage data-RAM access sequencer with wait states, stall, and fault reporting
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int DATA_W  = DATA_BUS_WIDTH,
    parameter int ADDR_W  = ADDR_BUS_WIDTH,
    parameter int SEL_W   = MEM_SEL_BUS_WIDTH,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read_flag,
    input  logic              mem_write_flag,
    input  logic [SEL_W-1:0]  mem_sel,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_write_data,
    input  logic              flush,
    input  logic              pipe_stall,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [SEL_W-1:0]  bus_sel,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ready,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_request,
    output logic [DATA_W-1:0] ram_read_data_out,
    output logic              access_fault,
    output logic              busy
);

    localparam int               CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    mem_ctrl_state_e   state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              fault_q, fault_d;

    logic req;
    logic aligned;

    assign req = (mem_read_flag | mem_write_flag) & ~flush;

    mem_access_ctrl_align_check #(
        .SEL_W (SEL_W)
    ) u_align_check (
        .sel_i      (mem_sel),
        .addr_lsb_i (mem_addr[1:0]),
        .aligned_o  (aligned)
    );

    // Next-state and datapath: latch the request in IDLE, hold the bus until ready or timeout, then one DONE slot
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_sel_d   = bus_sel_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        fault_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    if (aligned) begin
                        bus_req_d   = 1'b1;
                        bus_we_d    = mem_write_flag;
                        bus_addr_d  = {mem_addr[ADDR_W-1:2], 2'b00};
                        bus_sel_d   = mem_sel;
                        bus_wdata_d = mem_write_data;
                        cnt_d       = '0;
                        state_d     = ST_ACCESS;
                    end else begin
                        fault_d = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_ACCESS: begin
                if (bus_ready) begin
                    bus_req_d = 1'b0;
                    if (!bus_we_q) begin
                        rdata_d = bus_rdata;
                    end
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    bus_req_d = 1'b0;
                    rdata_d   = '0;
                    fault_d   = 1'b1;
                    state_d   = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                if (!pipe_stall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_sel_q   <= '0;
            bus_wdata_q <= '0;
            rdata_q     <= '0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_sel_q   <= bus_sel_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            fault_q     <= fault_d;
        end
    end

    assign bus_req           = bus_req_q;
    assign bus_we            = bus_we_q;
    assign bus_addr          = bus_addr_q;
    assign bus_sel           = bus_sel_q;
    assign bus_wdata         = bus_wdata_q;
    assign ram_read_data_out = rdata_q;
    assign access_fault      = fault_q;
    assign busy              = (state_q != ST_IDLE);
    // DONE deliberately releases the pipeline so the MEM instruction can move into MEM/WB
    assign stall_request     = ((state_q == ST_IDLE) & req) | (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_read_flag, mem_write_flag, flush, pipe_stall;
    logic [3:0]  mem_sel;
    logic [31:0] mem_addr, mem_write_data;
    logic        bus_req, bus_we, bus_ready;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;
    logic [3:0]  bus_sel;
    logic        stall_request, access_fault, busy;
    logic [31:0] ram_read_data_out;

    int checks   = 0;
    int failures = 0;

    int          obs_req, obs_stall, obs_faults, obs_fault_cyc, obs_done, obs_txns;
    bit          obs_unstable, obs_hang;
    logic        obs_we;
    logic [31:0] obs_addr, obs_wdata, obs_ram;
    logic [3:0]  obs_sel;
    logic [31:0] exp_ram;

    mem_access_ctrl #(
        .DATA_W (32), .ADDR_W (32), .SEL_W (4), .TIMEOUT (TO)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .mem_read_flag     (mem_read_flag),
        .mem_write_flag    (mem_write_flag),
        .mem_sel           (mem_sel),
        .mem_addr          (mem_addr),
        .mem_write_data    (mem_write_data),
        .flush             (flush),
        .pipe_stall        (pipe_stall),
        .bus_req           (bus_req),
        .bus_we            (bus_we),
        .bus_addr          (bus_addr),
        .bus_sel           (bus_sel),
        .bus_wdata         (bus_wdata),
        .bus_ready         (bus_ready),
        .bus_rdata         (bus_rdata),
        .stall_request     (stall_request),
        .ram_read_data_out (ram_read_data_out),
        .access_fault      (access_fault),
        .busy              (busy)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Legality straight from the access rules: full word on a word boundary, half on even, any single byte
    function automatic bit model_aligned(input logic [3:0] sel, input logic [31:0] addr);
        case (sel)
            4'b1111:                            return addr[1:0] == 2'b00;
            4'b0011, 4'b1100:                   return addr[0] == 1'b0;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Drives one MEM-stage access, plays the bus slave with a given wait count, and records what it sees
    task automatic run_txn(input logic rd, input logic wr, input logic [3:0] sel, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input logic [31:0] rdata,
                           input int stall_n, input bit rand_flush);
        int  cyc, acc, done_cnt;
        bit  in_done, done_seen, prev_req;
        cyc = 0; acc = 0; done_cnt = 0; done_seen = 0; prev_req = 0;
        obs_stall = 0; obs_faults = 0; obs_fault_cyc = -1; obs_txns = 0;
        obs_unstable = 0; obs_hang = 0; obs_ram = 'x;
        obs_we = 0; obs_addr = 0; obs_sel = 0; obs_wdata = 0;
        mem_read_flag = rd; mem_write_flag = wr; mem_sel = sel; mem_addr = addr;
        mem_write_data = wdata; flush = 0; pipe_stall = 0; bus_ready = 0;
        while (1) begin
            if (cyc > 200) begin
                obs_hang = 1;
                break;
            end
            in_done = busy && !bus_req;
            if (done_seen && !busy) break;
            if (in_done) begin
                done_seen = 1;
                mem_read_flag = 0; mem_write_flag = 0;
                pipe_stall = (done_cnt < stall_n);
                done_cnt++;
            end else begin
                pipe_stall = 0;
            end
            if (bus_req) begin
                if (!prev_req) obs_txns++;
                if (acc == 0) begin
                    obs_we = bus_we; obs_addr = bus_addr; obs_sel = bus_sel; obs_wdata = bus_wdata;
                end else if (bus_we !== obs_we || bus_addr !== obs_addr || bus_sel !== obs_sel
                             || bus_wdata !== obs_wdata) begin
                    obs_unstable = 1;
                end
                bus_ready = (acc == waits);
                bus_rdata = (acc == waits) ? rdata : ~rdata;
                flush = rand_flush ? 1'($urandom_range(0, 1)) : 1'b0;
                acc++;
            end else begin
                bus_ready = 0;
                flush = 0;
            end
            prev_req = bus_req;
            @(negedge clk);
            if (stall_request) obs_stall++;
            if (access_fault) begin
                obs_faults++;
                if (obs_fault_cyc < 0) obs_fault_cyc = cyc;
            end
            if (in_done && done_cnt == 1) obs_ram = ram_read_data_out;
            step();
            cyc++;
        end
        obs_req = acc;
        obs_done = done_cnt;
        mem_read_flag = 0; mem_write_flag = 0; flush = 0; pipe_stall = 0; bus_ready = 0;
    endtask

    task automatic test_reset();
        rst = 1; mem_read_flag = 0; mem_write_flag = 0; mem_sel = 0; mem_addr = 0;
        mem_write_data = 0; flush = 0; pipe_stall = 0; bus_ready = 0; bus_rdata = 0;
        step(); step();
        checks++;
        if ({bus_req, bus_we, bus_addr, bus_sel, bus_wdata} !== '0) begin
            failures++;
            $display("FAIL reset_bus got req=%0b we=%0b addr=%h sel=%b wdata=%h exp all 0",
                     bus_req, bus_we, bus_addr, bus_sel, bus_wdata);
        end
        checks++;
        if ({ram_read_data_out, access_fault, busy, stall_request} !== '0) begin
            failures++;
            $display("FAIL reset_state got ram=%h fault=%0b busy=%0b stall=%0b exp all 0",
                     ram_read_data_out, access_fault, busy, stall_request);
        end
        rst = 0;
        step();
        exp_ram = 32'h0;
    endtask

    task automatic test_read_zero_wait();
        run_txn(1, 0, 4'b1111, 32'h100, 32'h0, 0, 32'hDEADBEEF, 0, 0);
        exp_ram = 32'hDEADBEEF;
        checks++;
        if (obs_addr !== 32'h100 || obs_we !== 1'b0 || obs_req != 1) begin
            failures++;
            $display("FAIL rd0_bus got addr=%h we=%0b req_cycles=%0d exp addr=100 we=0 req_cycles=1",
                     obs_addr, obs_we, obs_req);
        end
        checks++;
        if (obs_stall != 2) begin
            failures++;
            $display("FAIL rd0_stall got %0d exp 2", obs_stall);
        end
        checks++;
        if (obs_ram !== exp_ram || obs_faults != 0 || obs_hang) begin
            failures++;
            $display("FAIL rd0_data got ram=%h faults=%0d hang=%0b exp ram=%h faults=0",
                     obs_ram, obs_faults, obs_hang, exp_ram);
        end
    endtask

    task automatic test_write_waits();
        run_txn(0, 1, 4'b0011, 32'h202, 32'h0000ABCD, 3, 32'h11112222, 0, 0);
        checks++;
        if (obs_we !== 1'b1 || obs_addr !== 32'h200 || obs_sel !== 4'b0011 || obs_wdata !== 32'h0000ABCD) begin
            failures++;
            $display("FAIL wr3_bus got we=%0b addr=%h sel=%b wdata=%h exp we=1 addr=200 sel=0011 wdata=0000abcd",
                     obs_we, obs_addr, obs_sel, obs_wdata);
        end
        checks++;
        if (obs_req != 4 || obs_stall != 5 || obs_unstable) begin
            failures++;
            $display("FAIL wr3_timing got req=%0d stall=%0d unstable=%0b exp req=4 stall=5 stable",
                     obs_req, obs_stall, obs_unstable);
        end
        checks++;
        if (obs_ram !== exp_ram) begin
            failures++;
            $display("FAIL wr3_ram_kept got %h exp %h", obs_ram, exp_ram);
        end
    endtask

    task automatic test_misaligned();
        run_txn(1, 0, 4'b1111, 32'h101, 32'h0, 0, 32'h0, 0, 0);
        checks++;
        if (obs_req != 0 || obs_faults != 1 || obs_fault_cyc != 1 || obs_stall != 1 || obs_done != 1) begin
            failures++;
            $display("FAIL mis_addr got req=%0d faults=%0d fcyc=%0d stall=%0d done=%0d exp 0 1 1 1 1",
                     obs_req, obs_faults, obs_fault_cyc, obs_stall, obs_done);
        end
        run_txn(1, 0, 4'b0000, 32'h100, 32'h0, 0, 32'h0, 0, 0);
        checks++;
        if (obs_req != 0 || obs_faults != 1 || obs_ram !== exp_ram) begin
            failures++;
            $display("FAIL mis_sel0 got req=%0d faults=%0d ram=%h exp req=0 faults=1 ram=%h",
                     obs_req, obs_faults, obs_ram, exp_ram);
        end
    endtask

    task automatic test_timeout();
        run_txn(1, 0, 4'b1111, 32'h300, 32'h0, 1000, 32'h5A5A5A5A, 0, 0);
        exp_ram = 32'h0;
        checks++;
        if (obs_req != TO || obs_faults != 1 || obs_fault_cyc != TO + 1 || obs_ram !== 32'h0) begin
            failures++;
            $display("FAIL timeout got req=%0d faults=%0d fcyc=%0d ram=%h exp req=%0d faults=1 fcyc=%0d ram=0",
                     obs_req, obs_faults, obs_fault_cyc, obs_ram, TO, TO + 1);
        end
    endtask

    task automatic test_flush();
        mem_read_flag = 1; mem_sel = 4'b1111; mem_addr = 32'h400; flush = 1;
        @(negedge clk);
        checks++;
        if (stall_request !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall got %0b exp 0", stall_request);
        end
        step();
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL flush_idle got req=%0b busy=%0b exp 0 0", bus_req, busy);
        end
        mem_read_flag = 0; flush = 0;
        step();
    endtask

    task automatic test_pipe_stall();
        run_txn(1, 0, 4'b0100, 32'h502, 32'h0, 1, 32'hCAFEF00D, 3, 0);
        exp_ram = 32'hCAFEF00D;
        checks++;
        if (obs_done != 4 || obs_txns != 1 || obs_req != 2 || obs_ram !== exp_ram) begin
            failures++;
            $display("FAIL pstall got done=%0d txns=%0d req=%0d ram=%h exp done=4 txns=1 req=2 ram=%h",
                     obs_done, obs_txns, obs_req, obs_ram, exp_ram);
        end
    endtask

    task automatic test_reset_mid_access();
        mem_read_flag = 1; mem_sel = 4'b1111; mem_addr = 32'h40; bus_ready = 0;
        step();
        checks++;
        if (bus_req !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_start got req=%0b exp 1", bus_req);
        end
        step();
        rst = 1; mem_read_flag = 0;
        step();
        checks++;
        if (bus_req !== 1'b0 || busy !== 1'b0 || ram_read_data_out !== 32'h0 || access_fault !== 1'b0) begin
            failures++;
            $display("FAIL rstmid got req=%0b busy=%0b ram=%h fault=%0b exp 0 0 0 0",
                     bus_req, busy, ram_read_data_out, access_fault);
        end
        rst = 0;
        step();
        checks++;
        if (busy !== 1'b0 || access_fault !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_after got busy=%0b fault=%0b exp 0 0", busy, access_fault);
        end
        exp_ram = 32'h0;
    endtask

    task automatic test_random();
        logic [3:0]  sel_tab [8] = '{4'b1111, 4'b0011, 4'b1100, 4'b0001, 4'b1000, 4'b0110, 4'b0000, 4'b1010};
        logic        rd, wr;
        logic [3:0]  sel;
        logic [31:0] addr, wdata, rdata;
        int          waits, stall_n, kind, exp_req, exp_stall, exp_faults;
        bit          ok;
        for (int it = 0; it < 40; it++) begin
            kind  = $urandom_range(0, 2);
            rd    = (kind != 1);
            wr    = (kind != 0);
            sel   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : sel_tab[$urandom_range(0, 7)];
            addr  = $urandom;
            wdata = $urandom;
            rdata = $urandom;
            waits = $urandom_range(0, TO + 2);
            stall_n = $urandom_range(0, 3);
            run_txn(rd, wr, sel, addr, wdata, waits, rdata, stall_n, 1);
            ok = model_aligned(sel, addr);
            if (!ok) begin
                exp_req = 0; exp_stall = 1; exp_faults = 1;
            end else if (waits >= TO) begin
                exp_req = TO; exp_stall = TO + 1; exp_faults = 1; exp_ram = 32'h0;
            end else begin
                exp_req = waits + 1; exp_stall = waits + 2; exp_faults = 0;
                if (!wr) exp_ram = rdata;
            end
            checks++;
            if (obs_req != exp_req || obs_stall != exp_stall || obs_faults != exp_faults || obs_hang) begin
                failures++;
                $display("FAIL rnd_timing it=%0d got req=%0d stall=%0d faults=%0d hang=%0b exp req=%0d stall=%0d faults=%0d",
                         it, obs_req, obs_stall, obs_faults, obs_hang, exp_req, exp_stall, exp_faults);
            end
            checks++;
            if (obs_ram !== exp_ram || obs_done != stall_n + 1) begin
                failures++;
                $display("FAIL rnd_result it=%0d got ram=%h done=%0d exp ram=%h done=%0d",
                         it, obs_ram, obs_done, exp_ram, stall_n + 1);
            end
            if (ok) begin
                checks++;
                if (obs_we !== wr || obs_addr !== {addr[31:2], 2'b00} || obs_sel !== sel
                    || obs_wdata !== wdata || obs_unstable || obs_txns != 1) begin
                    failures++;
                    $display("FAIL rnd_bus it=%0d got we=%0b addr=%h sel=%b wdata=%h unstable=%0b txns=%0d exp we=%0b addr=%h sel=%b wdata=%h",
                             it, obs_we, obs_addr, obs_sel, obs_wdata, obs_unstable, obs_txns,
                             wr, {addr[31:2], 2'b00}, sel, wdata);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_waits();
        test_misaligned();
        test_timeout();
        test_flush();
        test_read_zero_wait();
        test_pipe_stall();
        test_reset_mid_access();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
Sequences data-RAM accesses for the MEM stage over a ready/valid bus with variable wait states. It holds the pipeline by raising stall_request until the access completes. It captures the raw read word that feeds the MEM/WB register's ram_read_data_in. It also detects misaligned accesses and bus timeouts and reports them as faults.

Parameters:
- DATA_W, 32, data bus width (= DATA_BUS_WIDTH).
- ADDR_W, 32, address width (= ADDR_BUS_WIDTH).
- SEL_W, 4, byte-select width (= MEM_SEL_BUS_WIDTH).
- TIMEOUT, 64, maximum wait cycles in ACCESS before a fault; must be >= 2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- mem_read_flag  in  1  MEM stage requests a load.
- mem_write_flag  in  1  MEM stage requests a store.
- mem_sel  in  SEL_W  byte enables.
- mem_addr  in  ADDR_W  byte address.
- mem_write_data  in  DATA_W  store data, already lane-aligned.
- flush  in  1  pipeline flush of the MEM stage.
- pipe_stall  in  1  downstream stall; MEM/WB cannot advance this cycle.
- bus_req  out  1  bus request valid.
- bus_we  out  1  1 = write.
- bus_addr  out  ADDR_W  word address; [1:0] forced to 0.
- bus_sel  out  SEL_W  byte enables.
- bus_wdata  out  DATA_W  write data.
- bus_ready  in  1  bus completes the transaction this cycle.
- bus_rdata  in  DATA_W  read data, valid when bus_ready=1.
- stall_request  out  1  hold the IF..MEM stages.
- ram_read_data_out  out  DATA_W  captured raw read word, to MEM/WB.
- access_fault  out  1  one-cycle pulse on misalignment or timeout.
- busy  out  1  FSM not in IDLE.

Behaviour:
- Reset (clk edge with rst=1): state=IDLE, counter=0, all bus_* outputs=0, ram_read_data_out=0, access_fault=0. Reset mid-ACCESS drops bus_req on the next edge; no completion is reported.
- States: IDLE, ACCESS, DONE.
- req = (mem_read_flag | mem_write_flag) & ~flush. If both flags are set, the access is treated as a write.
- Alignment check:
  - sel 4'b1111 requires addr[1:0]=0.
  - sel 4'b0011 or 4'b1100 requires addr[0]=0.
  - A single-bit sel is always legal.
  - sel 0 or any other pattern is misaligned.
- IDLE, req & aligned:
  - Register bus_* from the mem_* inputs.
  - Go to ACCESS, counter=0.
  - bus_req=1 from the first ACCESS cycle.
- IDLE, req & misaligned:
  - No bus activity.
  - access_fault=1 for one cycle.
  - Go to DONE.
- IDLE, ~req: stay in IDLE.
- stall_request is combinational: (IDLE & req) | ACCESS. It is 0 in DONE.
- ACCESS:
  - bus_req, bus_we, bus_addr, bus_sel and bus_wdata stay stable until bus_ready.
  - On bus_ready: bus_req=0 next cycle. For a read, ram_read_data_out <= bus_rdata; for a write, ram_read_data_out is unchanged. Go to DONE.
  - Otherwise counter+1. When counter = TIMEOUT-1 with no bus_ready: bus_req=0, ram_read_data_out <= 0, access_fault=1 for one cycle, go to DONE.
  - flush is ignored in ACCESS; an issued transaction always completes.
- DONE:
  - Exactly one non-stalled cycle, so the MEM instruction advances into MEM/WB.
  - If pipe_stall=1, stay in DONE; no re-issue occurs because stall_request=0 in DONE.
  - If pipe_stall=0, go to IDLE.
- Minimum latency: request in cycle 0, bus_ready in cycle 1, stall_request high for 2 cycles, DONE in cycle 2.
- ram_read_data_out holds its value until the next read capture, timeout or reset.
- Sign/lane extraction is not done here; it happens downstream in WB.

Decomposition:
- Shared bus.v (already present): DATA_BUS_WIDTH, ADDR_BUS_WIDTH, MEM_SEL_BUS_WIDTH.
- Add to bus.v: MEM_CTRL_STATE_BUS (2 bits) with IDLE=0, ACCESS=1, DONE=2.
- Optional sub-module mem_align_check: combinational sel/addr legality. Everything else stays in one module.

Test Plan:
- Read, 0 wait: read, sel=1111, addr=0x100; bus_ready=1 in the first ACCESS cycle with rdata=0xDEADBEEF -> bus_addr=0x100, stall_request high 2 cycles, ram_read_data_out=0xDEADBEEF in DONE, access_fault=0.
- Write, 3 waits: write, sel=0011, addr=0x202, wdata=0x0000ABCD -> bus_we=1, bus_addr=0x200, bus_sel=0011, bus_req held exactly 4 cycles, stall_request high 5 cycles, ram_read_data_out unchanged.
- Misalignment: read, sel=1111, addr=0x101 -> bus_req never asserted, access_fault pulse in cycle 1, DONE in cycle 1; also sel=0000 -> fault.
- Timeout: TIMEOUT=8, bus_ready held 0 -> bus_req high 8 cycles then low, access_fault=1 once, ram_read_data_out=0.
- Flush/stall: flush=1 with read in IDLE -> no bus_req, stall_request=0. Read completes with pipe_stall=1 for 3 cycles -> DONE held 3 cycles, exactly one bus transaction.
- Reset mid-ACCESS: rst=1 during the 2nd wait cycle -> next cycle bus_req=0, state IDLE, ram_read_data_out=0, no fault.
